// File: rtl/pos_counter_pkg.sv
// Shared constants and helpers for the pos_counter block.
package pos_counter_pkg;

    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

    // A single-state prescaler (DIV=1) still needs a 1-bit register.
    function automatic int unsigned presc_width(input int unsigned div);
        return (div <= 1) ? 1 : $clog2(div);
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Divides enabled clock cycles by DIV, producing a one-cycle tick on the last count.
module tick_prescaler
    import pos_counter_pkg::*;
#(
    parameter int unsigned DIV = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clr_sync,
    output logic tick
);

    localparam int unsigned   PW   = presc_width(DIV);
    localparam logic [PW-1:0] LAST = PW'(DIV - 1);

    logic [PW-1:0] presc_q, presc_d;

    assign tick = en && (presc_q == LAST);

    always_comb begin
        presc_d = presc_q;
        if (clr_sync || tick) begin
            presc_d = '0;
        end else if (en) begin
            presc_d = presc_q + PW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_d;
        end
    end

endmodule

// File: rtl/pos_counter.sv
// Prescaled up/down position counter with wrap/saturate bounds and sync clear/load.
// Optional ping-pong motion and the bounce port are enabled by POS_COUNTER_BOUNCE_EN.
module pos_counter
    import pos_counter_pkg::*;
#(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned DIV   = 16,
    parameter int unsigned MAX   = 2**WIDTH - 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             dir,
    input  logic             wrap,
`ifdef POS_COUNTER_BOUNCE_EN
    input  logic             bounce,
`endif
    output logic [WIDTH-1:0] pos,
    output logic             dir_q,
    output logic             step,
    output logic             edge_hit
);

    localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);

    logic             tick;
    logic             bounce_en;
    logic             eff_dir;
    logic [WIDTH-1:0] pos_q, pos_d;
    logic             dir_q_q, dir_d;
    logic             step_q, step_d;
    logic             edge_hit_q, edge_hit_d;

`ifdef POS_COUNTER_BOUNCE_EN
    assign bounce_en = bounce;
`else
    assign bounce_en = 1'b0;
`endif

    tick_prescaler #(
        .DIV (DIV)
    ) u_presc (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .clr_sync (clr || load),
        .tick     (tick)
    );

    // Bounce follows its own direction register; otherwise dir is taken live at the tick edge.
    assign eff_dir = bounce_en ? dir_q_q : dir;

    always_comb begin
        pos_d      = pos_q;
        dir_d      = bounce_en ? dir_q_q : dir;
        step_d     = 1'b0;
        edge_hit_d = 1'b0;
        if (clr) begin
            pos_d = '0;
            dir_d = DIR_UP;
        end else if (load) begin
            pos_d = (load_val > MAX_V) ? MAX_V : load_val;
            dir_d = dir;
        end else if (tick) begin
            step_d = 1'b1;
            if (eff_dir == DIR_UP) begin
                if (pos_q != MAX_V) begin
                    pos_d = pos_q + WIDTH'(1);
                end else begin
                    edge_hit_d = 1'b1;
                    if (bounce_en) begin
                        pos_d = MAX_V - WIDTH'(1);
                        dir_d = DIR_DOWN;
                    end else if (wrap) begin
                        pos_d = '0;
                    end
                end
            end else begin
                if (pos_q != '0) begin
                    pos_d = pos_q - WIDTH'(1);
                end else begin
                    edge_hit_d = 1'b1;
                    if (bounce_en) begin
                        pos_d = WIDTH'(1);
                        dir_d = DIR_UP;
                    end else if (wrap) begin
                        pos_d = MAX_V;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pos_q      <= '0;
            dir_q_q    <= DIR_UP;
            step_q     <= 1'b0;
            edge_hit_q <= 1'b0;
        end else begin
            pos_q      <= pos_d;
            dir_q_q    <= dir_d;
            step_q     <= step_d;
            edge_hit_q <= edge_hit_d;
        end
    end

    assign pos      = pos_q;
    assign dir_q    = dir_q_q;
    assign step     = step_q;
    assign edge_hit = edge_hit_q;

endmodule
